mips_multicycle_control: RTL and testbench
==========================================

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 Parameters: none; state encoding, opcodes and control values are fixed by this document.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-004 Op  input  6  opcode field, instr[31:26], from instruction register.
REQ-005 MemReady  input  1  memory handshake; 1 = current read/write completes this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-007 ALUSrcB  output  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-008 ALUOp  output  2  to the ALU control unit: 00 add, 01 subtract (branch compare), 10 decode Funct.
REQ-009 PCSource  output  2  00 ALU result, 01 ALUOut register, 10 jump target.
REQ-010 State  output  4  current state encoding, for debug and verification.
REQ-011 IllegalOp  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-012 Moore FSM; all outputs decode from registered state only, except the MemReady gating in REQ-014.
REQ-013 State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, JUMP=9, ILLEGAL=10; codes 11-15 go to FETCH on the next edge, with all outputs 0.
REQ-014 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=MemReady; hold FETCH while MemReady=0, else go to DECODE.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by Op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 000010 -> JUMP, any other -> ILLEGAL.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; Op=100011 -> MEMREAD, Op=101011 -> MEMWRITE.
REQ-017 MEMREAD: MemRead=1, IorD=1; hold while MemReady=0; MemReady=1 -> MEMWB.
REQ-018 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
REQ-019 MEMWRITE: MemWrite=1, IorD=1; hold while MemReady=0; MemReady=1 -> FETCH.
REQ-020 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB; ALUWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
REQ-022 JUMP: PCWrite=1, PCSource=10 -> FETCH; ILLEGAL: IllegalOp=1, no write enables -> FETCH.
REQ-023 Any output not listed for a state is 0 in that state.
REQ-024 Cycle counts with MemReady held at 1: R-type 4, lw 5, sw 4, beq 3, j 3, illegal 3.
REQ-025 Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. MemRead/MemWrite stay asserted throughout the stall. No write enable pulses twice for one instruction.
REQ-026 Op is sampled only in DECODE and MEMADR; Op changes in other states have no effect.

Reset
REQ-027 reset=1 at a rising edge forces State=FETCH. Reset has priority over every transition, including mid-instruction and mid-stall.
REQ-028 While reset=1, outputs take their FETCH values. PCWrite and IRWrite are forced to 0 regardless of MemReady. IllegalOp=0.
REQ-029 The first instruction fetch begins on the first edge with reset=0.

Verification
REQ-030 Reset then Op=000000, MemReady=1 -> State 0,1,6,7,0; ALUOp=10 only in state 6; RegWrite=RegDst=1 only in state 7.
REQ-031 Op=100011, MemReady low for 2 cycles in MEMREAD -> State 0,1,2,3,3,3,4,0; MemRead=IorD=1 for all three state-3 cycles; RegWrite=MemtoReg=1 once.
REQ-032 Op=101011, MemReady=0 for 3 cycles in FETCH -> PCWrite/IRWrite low for 3 cycles, then high for 1 cycle. Sequence continues 1,2,5,0 with exactly one MemWrite cycle.
REQ-033 Op=000100 then Op=000010 -> first instruction: state 8 with ALUOp=01, PCWriteCond=1, PCSource=01. Second instruction: state 9 with PCWrite=1, PCSource=10.
REQ-034 Op=111111 -> State 0,1,10,0; IllegalOp pulses for exactly 1 cycle; no write enables asserted.
REQ-035 reset asserted during MEMWRITE stall -> next State=0 with MemWrite=0. After release, the fetch proceeds normally.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control unit. This is a Moore FSM that sequences
// fetch, decode, memory, execute, branch and jump for R-type, lw, sw, beq
// and j. Any other opcode goes through a one-cycle ILLEGAL state.
//
// Ports
//   clk_i, reset_i     : clock and synchronous active-high reset
//   Op_i[5:0]          : opcode field instr[31:26]
//   MemReady_i         : memory handshake, 1 = access completes this cycle
//   PCWrite_o .. ALUSrcA_o : single-bit datapath controls
//   ALUSrcB_o[1:0]     : 00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
//   ALUOp_o[1:0]       : 00 add, 01 subtract, 10 decode Funct
//   PCSource_o[1:0]    : 00 ALU result, 01 ALUOut, 10 jump target
//   State_o[3:0]       : current state encoding (debug)
//   IllegalOp_o        : one-cycle pulse on an unsupported opcode
module mips_multicycle_control (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] Op_i,
  input  logic       MemReady_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic       RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUOp_o,
  output logic [1:0] PCSource_o,
  output logic [3:0] State_o,
  output logic       IllegalOp_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ILLEGAL  = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  // Op is only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = MemReady_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        // Op is meant to be held since DECODE. If it changed to something
        // other than lw/sw in between, treat the instruction as illegal.
        if (Op_i == OP_LW)      state_d = S_MEMREAD;
        else if (Op_i == OP_SW) state_d = S_MEMWRITE;
        else                    state_d = S_ILLEGAL;
      end
      S_MEMREAD:  state_d = MemReady_i ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = MemReady_i ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      default:    state_d = S_FETCH;  // MEMWB, ALUWB, BRANCH, JUMP, ILLEGAL, 11-15
    endcase
  end

  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALUOp_o       = 2'b00;
    PCSource_o    = 2'b00;
    IllegalOp_o   = 1'b0;
    State_o       = state_q;
    if (reset_i) begin
      // While reset is held, show FETCH with the write enables suppressed.
      State_o   = S_FETCH;
      MemRead_o = 1'b1;
      ALUSrcB_o = 2'b01;
    end else begin
      case (state_q)
        S_FETCH: begin
          MemRead_o = 1'b1;
          ALUSrcB_o = 2'b01;
          IRWrite_o = MemReady_i;
          PCWrite_o = MemReady_i;
        end
        S_DECODE:   ALUSrcB_o = 2'b11;
        S_MEMADR: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = 2'b10;
        end
        S_MEMREAD: begin
          MemRead_o = 1'b1;
          IorD_o    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite_o = 1'b1;
          MemtoReg_o = 1'b1;
        end
        S_MEMWRITE: begin
          MemWrite_o = 1'b1;
          IorD_o     = 1'b1;
        end
        S_EXECUTE: begin
          ALUSrcA_o = 1'b1;
          ALUOp_o   = 2'b10;
        end
        S_ALUWB: begin
          RegWrite_o = 1'b1;
          RegDst_o   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA_o     = 1'b1;
          ALUOp_o       = 2'b01;
          PCWriteCond_o = 1'b1;
          PCSource_o    = 2'b01;
        end
        S_JUMP: begin
          PCWrite_o  = 1'b1;
          PCSource_o = 2'b10;
        end
        S_ILLEGAL:  IllegalOp_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control. Each step drives the inputs
// for one cycle and pushes the expected state and control word into a
// scoreboard. The step then pops that entry and compares it with the DUT
// outputs. Expected control words come from a per-state table.
module tb_mips_multicycle_control;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [5:0] Op_i;
  logic       MemReady_i;
  logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o;
  logic       IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o;
  logic [1:0] ALUSrcB_o, ALUOp_o, PCSource_o;
  logic [3:0] State_o;
  logic       IllegalOp_o;

  mips_multicycle_control dut (
    .clk_i(clk_i), .reset_i(reset_i), .Op_i(Op_i), .MemReady_i(MemReady_i),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
    .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
    .PCSource_o(PCSource_o), .State_o(State_o), .IllegalOp_o(IllegalOp_o)
  );

  always #5 clk_i = ~clk_i;

  // {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
  //  RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0], IllegalOp}
  logic [16:0] obs_ctrl;
  assign obs_ctrl = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
                     IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o,
                     ALUSrcB_o, ALUOp_o, PCSource_o, IllegalOp_o};

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [16:0] ctrl;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  function automatic logic [16:0] exp_ctrl(input int st, input logic mr, input logic rst);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    if (rst) begin
      mrd = 1'b1; asb = 2'b01;
    end else begin
      case (st)
        0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
        1:  asb = 2'b11;
        2:  begin asa = 1'b1; asb = 2'b10; end
        3:  begin mrd = 1'b1; iord = 1'b1; end
        4:  begin rw = 1'b1; m2r = 1'b1; end
        5:  begin mwr = 1'b1; iord = 1'b1; end
        6:  begin asa = 1'b1; aop = 2'b10; end
        7:  begin rw = 1'b1; rdst = 1'b1; end
        8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
        9:  begin pcw = 1'b1; pcs = 2'b10; end
        10: ill = 1'b1;
        default: ;
      endcase
    end
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill};
  endfunction

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    n_checks++;
    assert (State_o === e.st) else begin
      n_fails++;
      $error("FAIL %s state: observed %0d expected %0d", e.tag, State_o, e.st);
    end
    n_checks++;
    assert (obs_ctrl === e.ctrl) else begin
      n_fails++;
      $error("FAIL %s ctrl: observed %b expected %b", e.tag, obs_ctrl, e.ctrl);
    end
  endtask

  // One cycle: drive the inputs after the falling edge, then sample before the next rising edge.
  task automatic step(input logic rst, input logic mr, input logic [5:0] op,
                      input int st, input string tag);
    exp_t e;
    @(negedge clk_i);
    reset_i    = rst;
    MemReady_i = mr;
    Op_i       = op;
    e.tag  = tag;
    e.st   = st[3:0];
    e.ctrl = exp_ctrl(st, mr, rst);
    sb.push_back(e);
    #2;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i = 1'b1; MemReady_i = 1'b1; Op_i = RT;
    @(posedge clk_i);

    // Reset held with MemReady=1 still keeps PCWrite/IRWrite low.
    step(1, 1, RT, 0, "rst0");
    step(1, 0, RT, 0, "rst1");

    // R-type. Op changes after DECODE must not matter.
    step(0, 1, RT,  0, "r_fetch");
    step(0, 1, RT,  1, "r_decode");
    step(0, 1, BAD, 6, "r_exec");
    step(0, 1, LW,  7, "r_aluwb");

    // lw with a two-cycle stall in MEMREAD.
    step(0, 1, LW, 0, "lw_fetch");
    step(0, 1, LW, 1, "lw_decode");
    step(0, 1, LW, 2, "lw_memadr");
    step(0, 0, LW, 3, "lw_mrd_stall0");
    step(0, 0, LW, 3, "lw_mrd_stall1");
    step(0, 1, LW, 3, "lw_mrd_done");
    step(0, 1, LW, 4, "lw_memwb");

    // sw with a three-cycle stall in FETCH.
    step(0, 0, SW, 0, "sw_fetch_stall0");
    step(0, 0, SW, 0, "sw_fetch_stall1");
    step(0, 0, SW, 0, "sw_fetch_stall2");
    step(0, 1, SW, 0, "sw_fetch");
    step(0, 1, SW, 1, "sw_decode");
    step(0, 1, SW, 2, "sw_memadr");
    step(0, 1, SW, 5, "sw_memwrite");

    // beq, then j.
    step(0, 1, BEQ, 0, "beq_fetch");
    step(0, 1, BEQ, 1, "beq_decode");
    step(0, 1, BEQ, 8, "beq_branch");
    step(0, 1, JMP, 0, "j_fetch");
    step(0, 1, JMP, 1, "j_decode");
    step(0, 1, JMP, 9, "j_jump");

    // Unsupported opcode.
    step(0, 1, BAD, 0,  "ill_fetch");
    step(0, 1, BAD, 1,  "ill_decode");
    step(0, 1, BAD, 10, "ill_state");

    // Reset during a MEMWRITE stall, then a normal R-type.
    step(0, 1, SW, 0, "rsw_fetch");
    step(0, 1, SW, 1, "rsw_decode");
    step(0, 1, SW, 2, "rsw_memadr");
    step(0, 0, SW, 5, "rsw_stall0");
    step(0, 0, SW, 5, "rsw_stall1");
    step(1, 0, SW, 0, "rsw_reset");
    step(0, 1, RT, 0, "post_fetch");
    step(0, 1, RT, 1, "post_decode");
    step(0, 1, RT, 6, "post_exec");
    step(0, 1, RT, 7, "post_aluwb");
    step(0, 1, RT, 0, "post_fetch2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
